// File: rtl/carrier_acq_sequencer.sv
// carrier_acq_sequencer
// Acquisition/tracking controller for the carrier loop filter. Sequences
// accumulator clear, frequency sweep, settle and narrow-band track, selects
// wide (acquisition) or narrow (tracking) lead/lag exponents, and re-acquires
// on sweep timeout or loss of lock.
//
// Optional feature macro: CARRIER_ACQ_GEARSHIFT_EN
//   defined   : exponents step from acquisition toward tracking values by one
//               every 256 loop updates in TRACK (downward steps jump at once).
//   undefined : exponents switch to tracking values on TRACK entry.
//
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_enable                       sequencer run; low forces IDLE
//   i_clk_en                       loop-filter update strobe (qualifies counting)
//   i_carrier_lock                 lock flag, observed only on update strobes
//   i_acq_lead_exp/i_acq_lag_exp   acquisition exponents
//   i_trk_lead_exp/i_trk_lag_exp   tracking exponents
//   i_dwell_count                  sweep timeout in updates (0 = none)
//   i_settle_count                 locked updates before TRACK (0 acts as 1)
//   i_loss_count                   unlocked updates in TRACK before re-acquire (0 = never)
//   o_lead_exp/o_lag_exp           exponents to lead/lag gains
//   o_sweep_enable                 sweep request to lag accumulator
//   o_clear_accum                  one-clk accumulator clear pulse
//   o_acquired                     high only in TRACK
//   o_state                        current state code
//   o_reacq_count                  saturating re-acquisition counter
module carrier_acq_sequencer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned EXP_W = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_clk_en,
  input  logic             i_carrier_lock,
  input  logic [EXP_W-1:0] i_acq_lead_exp,
  input  logic [EXP_W-1:0] i_acq_lag_exp,
  input  logic [EXP_W-1:0] i_trk_lead_exp,
  input  logic [EXP_W-1:0] i_trk_lag_exp,
  input  logic [CNT_W-1:0] i_dwell_count,
  input  logic [CNT_W-1:0] i_settle_count,
  input  logic [CNT_W-1:0] i_loss_count,
  output logic [EXP_W-1:0] o_lead_exp,
  output logic [EXP_W-1:0] o_lag_exp,
  output logic             o_sweep_enable,
  output logic             o_clear_accum,
  output logic             o_acquired,
  output logic [2:0]       o_state,
  output logic [7:0]       o_reacq_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SWEEP  = 3'd2,
    S_SETTLE = 3'd3,
    S_TRACK  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_reacq;
  logic             w_reacq_inc;
  logic             r_sweep;
  logic             r_clear;
  logic             r_acq;

  // count+1 computed one bit wider so threshold compares never wrap
  logic [CNT_W:0]   w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_sat;
  logic [CNT_W:0]   w_settle_thr;
  logic [CNT_W:0]   w_dwell_thr;
  logic [CNT_W:0]   w_loss_thr;

  assign w_cnt_inc    = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_cnt_sat    = (&r_cnt) ? r_cnt : w_cnt_inc[CNT_W-1:0];
  assign w_settle_thr = (i_settle_count == '0) ? (CNT_W+1)'(1) : {1'b0, i_settle_count};
  assign w_dwell_thr  = {1'b0, i_dwell_count};
  assign w_loss_thr   = {1'b0, i_loss_count};

  // Next-state, counter and re-acquisition decisions
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_reacq_inc = 1'b0;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
        S_CLEAR: begin
          w_state_nxt = S_SWEEP;
          w_cnt_nxt   = '0;
        end
        S_SWEEP: begin
          if (i_clk_en) begin
            if (i_carrier_lock) begin
              w_state_nxt = S_SETTLE;
              w_cnt_nxt   = '0;
            end else if ((i_dwell_count != '0) && (w_cnt_inc >= w_dwell_thr)) begin
              w_state_nxt = S_CLEAR;
              w_cnt_nxt   = '0;
              w_reacq_inc = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_sat;
            end
          end
        end
        S_SETTLE: begin
          if (i_clk_en) begin
            if (!i_carrier_lock) begin
              w_state_nxt = S_SWEEP;
              w_cnt_nxt   = '0;
            end else if (w_cnt_inc >= w_settle_thr) begin
              w_state_nxt = S_TRACK;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_sat;
            end
          end
        end
        S_TRACK: begin
          if (i_clk_en) begin
            if (i_carrier_lock) begin
              w_cnt_nxt = '0;
            end else if ((i_loss_count != '0) && (w_cnt_inc >= w_loss_thr)) begin
              w_state_nxt = S_CLEAR;
              w_cnt_nxt   = '0;
              w_reacq_inc = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_sat;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counters and state-decoded output flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_reacq <= '0;
      r_sweep <= 1'b0;
      r_clear <= 1'b0;
      r_acq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_reacq_inc && (r_reacq != 8'hFF)) begin
        r_reacq <= r_reacq + 8'd1;
      end
      r_sweep <= (w_state_nxt == S_SWEEP);
      r_clear <= (w_state_nxt == S_CLEAR);
      r_acq   <= (w_state_nxt == S_TRACK);
    end
  end

  assign o_state        = r_state;
  assign o_reacq_count  = r_reacq;
  assign o_sweep_enable = r_sweep;
  assign o_clear_accum  = r_clear;
  assign o_acquired     = r_acq;

`ifdef CARRIER_ACQ_GEARSHIFT_EN
  logic [7:0]       r_gear_tmr;
  logic [EXP_W-1:0] r_gear_lead;
  logic [EXP_W-1:0] r_gear_lag;
  logic             w_gear_hold;
  logic             w_gear_tick;

  // Gear runs only while TRACK is held; any other cycle reloads entry values
  assign w_gear_hold = (r_state == S_TRACK) && (w_state_nxt == S_TRACK);
  assign w_gear_tick = w_gear_hold && i_clk_en && (r_gear_tmr == 8'hFF);

  // Downward targets jump immediately; upward targets step by one per tick
  function automatic logic [EXP_W-1:0] f_gear(input logic [EXP_W-1:0] cur,
                                               input logic [EXP_W-1:0] trk,
                                               input logic             tick);
    if (trk < cur) begin
      return trk;
    end else if (tick && (cur != trk)) begin
      return cur + EXP_W'(1);
    end else begin
      return cur;
    end
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset || !w_gear_hold) begin
      r_gear_tmr  <= '0;
      r_gear_lead <= f_gear(i_acq_lead_exp, i_trk_lead_exp, 1'b0);
      r_gear_lag  <= f_gear(i_acq_lag_exp, i_trk_lag_exp, 1'b0);
    end else begin
      if (i_clk_en) begin
        r_gear_tmr <= r_gear_tmr + 8'd1;
      end
      r_gear_lead <= f_gear(r_gear_lead, i_trk_lead_exp, w_gear_tick);
      r_gear_lag  <= f_gear(r_gear_lag, i_trk_lag_exp, w_gear_tick);
    end
  end

  assign o_lead_exp = r_acq ? r_gear_lead : i_acq_lead_exp;
  assign o_lag_exp  = r_acq ? r_gear_lag  : i_acq_lag_exp;
`else
  assign o_lead_exp = r_acq ? i_trk_lead_exp : i_acq_lead_exp;
  assign o_lag_exp  = r_acq ? i_trk_lag_exp  : i_acq_lag_exp;
`endif

endmodule

// File: doc/carrier_acq_sequencer.md
Name: carrier_acq_sequencer

Overview:
- Acquisition/tracking controller for the carrier loop filter.
- Sequences accumulator clear, frequency sweep, settle, and narrow-band track.
- Selects wide (acquisition) or narrow (tracking) lead/lag exponents and re-acquires on timeout or loss of lock.
- Sits beside the carrier loop: consumes its loop-update strobe and lock flag, drives its sweepEnable/clearAccum/leadExp/lagExp controls in place of static register bits.

Parameters:
- CNT_W, 16: width of dwell/settle/loss counters and threshold inputs.
- EXP_W, 5: width of lead/lag exponent fields.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  sequencer run; low forces IDLE
- clkEn  in  1  loop-filter update strobe; all counting is qualified by it
- carrierLock  in  1  lock flag from the carrier loop lock detector
- acqLeadExp  in  EXP_W  acquisition lead exponent
- acqLagExp  in  EXP_W  acquisition lag exponent
- trkLeadExp  in  EXP_W  tracking lead exponent
- trkLagExp  in  EXP_W  tracking lag exponent
- dwellCount  in  CNT_W  sweep timeout in updates; 0 = no timeout
- settleCount  in  CNT_W  locked updates required before TRACK
- lossCount  in  CNT_W  consecutive unlocked updates in TRACK before re-acquire; 0 = never
- leadExp  out  EXP_W  exponent to lead gain
- lagExp  out  EXP_W  exponent to lag gain
- sweepEnable  out  1  sweep request to lag accumulator
- clearAccum  out  1  one-clk accumulator clear pulse
- acquired  out  1  high only in TRACK
- state  out  3  current state code
- reacqCount  out  8  saturating re-acquisition counter

Behaviour:
- All outputs are registered and decoded from the state register.
- Reset values: state IDLE (0), leadExp=acqLeadExp, lagExp=acqLagExp (combinational select of the live inputs), sweepEnable 0, clearAccum 0, acquired 0, reacqCount 0, all counters 0.
- State codes: IDLE=0, CLEAR=1, SWEEP=2, SETTLE=3, TRACK=4. Codes 5-7 are illegal and go to IDLE on the next clk.
- enable low in any state: next clk goes to IDLE and clears counters. This has priority over every other transition. reacqCount holds.
- IDLE:
  - Outputs at acquisition settings, sweepEnable 0.
  - enable high -> CLEAR on next clk (not clkEn-qualified).
- CLEAR:
  - clearAccum=1 for exactly one clk.
  - Unconditional -> SWEEP on next clk; counter cleared.
- SWEEP:
  - sweepEnable=1, acquisition exponents.
  - On clkEn with carrierLock=1 -> SETTLE, counter cleared.
  - On clkEn with carrierLock=0: counter++. On the dwellCount-th such update (dwellCount != 0) -> CLEAR, reacqCount++.
- SETTLE:
  - sweepEnable=0, acquisition exponents.
  - On clkEn with carrierLock=0 -> SWEEP, counter cleared, no clear pulse.
  - On clkEn with carrierLock=1: counter++. On the settleCount-th locked update -> TRACK. settleCount=0 behaves as 1.
- TRACK:
  - acquired=1, sweepEnable=0, tracking exponents.
  - Loss counter increments on clkEn with carrierLock=0 and resets to 0 on clkEn with carrierLock=1.
  - On the lossCount-th consecutive unlocked update (lossCount != 0) -> CLEAR, reacqCount++.
- reacqCount saturates at 255 and clears only on reset.
- Counters saturate at all-ones. They never wrap.
- Threshold inputs are sampled live. A threshold lowered below the current count takes effect on the next qualifying update, because the compare is count+1 >= threshold.
- clkEn with no other condition in IDLE or CLEAR: ignored.
- carrierLock is only observed on clkEn cycles.

Optional Feature:
- Macro: CARRIER_ACQ_GEARSHIFT_EN.
- Defined:
  - On TRACK entry, leadExp/lagExp start at the acquisition values.
  - Every 256 clkEn updates in TRACK, each exponent increments by 1 until it equals its tracking value.
  - If a tracking value is below its acquisition value, that exponent jumps directly.
  - The gear timer resets on leaving TRACK.
- Undefined: exponents switch to the tracking values in the same clk that state becomes TRACK. No gear timer logic exists.

Test Plan:
- Reset, enable=1, carrierLock=0, dwellCount=4, clkEn every 4 clks -> state 0->1->2; clearAccum high exactly 1 clk; after 4th clkEn, CLEAR re-entered; reacqCount=1.
- In SWEEP, carrierLock=1 on a clkEn, settleCount=3, lock held -> SETTLE after that clkEn; TRACK after the 3rd locked clkEn; acquired=1; exponents = trk values (macro off); sweepEnable=0.
- In SETTLE, drop carrierLock on 2nd update -> SWEEP, sweepEnable=1, no clearAccum pulse, reacqCount unchanged.
- In TRACK, lossCount=5, pattern unlocked×4, locked, unlocked×5 -> remains TRACK until the 5th consecutive unlock, then CLEAR; reacqCount increments.
- Drive 300 timeouts -> reacqCount saturates at 255. Drop enable mid-SWEEP -> IDLE next clk, reacqCount holds. Assert reset mid-TRACK -> all reset values next clk.
- Macro on, acqLagExp=8, trkLagExp=11 -> lagExp 8 at TRACK entry, 9/10/11 after 256/512/768 updates, then holds.
